// File: rtl/wb_stage.sv
// Writeback stage: one-entry stage register feeding a 64-bit register file with
// bypassed read ports, a retired-instruction counter and a run/drain/halt controller.
module wb_stage #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             valid_i,
  input  logic             wen_i,
  input  logic [4:0]       rd_i,
  input  logic [XLEN-1:0]  wdata_i,
  input  logic [63:0]      pc_i,
  input  logic             exit_i,
  output logic             ready_o,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  output logic [XLEN-1:0]  rdata1_o,
  output logic [XLEN-1:0]  rdata2_o,
  output logic             commit_valid_o,
  output logic [63:0]      commit_pc_o,
  output logic [4:0]       commit_rd_o,
  output logic [XLEN-1:0]  commit_wdata_o,
  output logic [CNT_W-1:0] retired_o,
  output logic             halted_o,
  output logic [XLEN-1:0]  exit_code_o,
  output logic [63:0]      exit_pc_o
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_s_valid;
  logic              r_s_wen;
  logic [4:0]        r_s_rd;
  logic [XLEN-1:0]   r_s_wdata;
  logic [63:0]       r_s_pc;

  logic [XLEN-1:0]   r_regs [NREG];
  logic [CNT_W-1:0]  r_retired;
  logic [XLEN-1:0]   r_exit_code;
  logic [63:0]       r_exit_pc;

  logic              w_ready;
  logic              w_accept;
  logic              w_write;
  logic [XLEN-1:0]   w_rdata1;
  logic [XLEN-1:0]   w_rdata2;

  assign w_ready  = (r_state == ST_RUN);
  assign w_accept = valid_i && w_ready;
  assign w_write  = r_s_valid && r_s_wen && (r_s_rd != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // DRAIN lasts exactly one cycle: the exit bundle is always staged while in it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:    if (w_accept && exit_i) w_state_nxt = ST_DRAIN;
      ST_DRAIN:  w_state_nxt = ST_HALTED;
      ST_HALTED: w_state_nxt = ST_HALTED;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s_valid <= 1'b0;
      r_s_wen   <= 1'b0;
      r_s_rd    <= '0;
      r_s_wdata <= '0;
      r_s_pc    <= '0;
    end else begin
      r_s_valid <= w_accept;
      if (w_accept) begin
        r_s_wen   <= wen_i;
        r_s_rd    <= rd_i;
        r_s_wdata <= wdata_i;
        r_s_pc    <= pc_i;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_write) begin
      r_regs[r_s_rd] <= r_s_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_retired   <= '0;
      r_exit_code <= '0;
      r_exit_pc   <= '0;
    end else begin
      if (r_s_valid) r_retired <= r_retired + CNT_W'(1);
      // Exit code is x10 as it stands after this commit, so forward the write.
      if (r_state == ST_DRAIN && r_s_valid) begin
        r_exit_pc   <= r_s_pc;
        r_exit_code <= (w_write && r_s_rd == 5'd10) ? r_s_wdata : r_regs[10];
      end
    end
  end

  always_comb begin
    w_rdata1 = '0;
    w_rdata2 = '0;
    if (rs1_i != '0) w_rdata1 = (w_write && r_s_rd == rs1_i) ? r_s_wdata : r_regs[rs1_i];
    if (rs2_i != '0) w_rdata2 = (w_write && r_s_rd == rs2_i) ? r_s_wdata : r_regs[rs2_i];
  end

  assign ready_o        = w_ready;
  assign rdata1_o       = w_rdata1;
  assign rdata2_o       = w_rdata2;
  assign commit_valid_o = r_s_valid;
  assign commit_pc_o    = r_s_pc;
  assign commit_rd_o    = w_write ? r_s_rd : '0;
  assign commit_wdata_o = w_write ? r_s_wdata : '0;
  assign retired_o      = r_retired;
  assign halted_o       = (r_state == ST_HALTED);
  assign exit_code_o    = r_exit_code;
  assign exit_pc_o      = r_exit_pc;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: per-cycle vector table, commit scoreboard,
// and hand-written reset/exit sequences; a 2-bit-counter instance covers wrap.
module tb_wb_stage;

  logic        clock;
  logic        reset;
  logic        valid_i, wen_i, exit_i;
  logic [4:0]  rd_i, rs1_i, rs2_i;
  logic [63:0] wdata_i, pc_i;
  logic        ready_o, commit_valid_o, halted_o;
  logic [63:0] rdata1_o, rdata2_o, commit_pc_o, commit_wdata_o, retired_o;
  logic [63:0] exit_code_o, exit_pc_o;
  logic [4:0]  commit_rd_o;

  logic        s_ready, s_cv, s_halted;
  logic [63:0] s_r1, s_r2, s_cpc, s_cwd, s_xcode, s_xpc;
  logic [4:0]  s_crd;
  logic [1:0]  s_ret;

  int n_checks = 0;
  int n_fail   = 0;

  wb_stage #(.XLEN(64), .NREG(32), .CNT_W(64)) u_dut (
    .clock(clock), .reset(reset), .valid_i(valid_i), .wen_i(wen_i), .rd_i(rd_i),
    .wdata_i(wdata_i), .pc_i(pc_i), .exit_i(exit_i), .ready_o(ready_o),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rdata1_o(rdata1_o), .rdata2_o(rdata2_o),
    .commit_valid_o(commit_valid_o), .commit_pc_o(commit_pc_o),
    .commit_rd_o(commit_rd_o), .commit_wdata_o(commit_wdata_o),
    .retired_o(retired_o), .halted_o(halted_o), .exit_code_o(exit_code_o),
    .exit_pc_o(exit_pc_o)
  );

  wb_stage #(.XLEN(64), .NREG(32), .CNT_W(2)) u_small (
    .clock(clock), .reset(reset), .valid_i(valid_i), .wen_i(wen_i), .rd_i(rd_i),
    .wdata_i(wdata_i), .pc_i(pc_i), .exit_i(exit_i), .ready_o(s_ready),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rdata1_o(s_r1), .rdata2_o(s_r2),
    .commit_valid_o(s_cv), .commit_pc_o(s_cpc),
    .commit_rd_o(s_crd), .commit_wdata_o(s_cwd),
    .retired_o(s_ret), .halted_o(s_halted), .exit_code_o(s_xcode),
    .exit_pc_o(s_xpc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        v, wen, ex;
    logic [4:0]  rd, rs1, rs2;
    logic [63:0] wdata, pc;
    logic [63:0] e_r1, e_r2;
    logic        e_ready, e_cv, e_halt;
    logic [63:0] e_ret, e_xcode, e_xpc;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    logic [4:0]  rd;
    logic [63:0] wdata;
  } commit_t;

  commit_t exp_q[$];
  vec_t    vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic v, input logic wen, input logic [4:0] rd, input logic [63:0] wdata,
    input logic [63:0] pc, input logic ex, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [63:0] r1, input logic [63:0] r2, input logic rdy, input logic cv,
    input logic halt, input logic [63:0] ret, input logic [63:0] xc, input logic [63:0] xp);
    vec_t t;
    t.v = v; t.wen = wen; t.rd = rd; t.wdata = wdata; t.pc = pc; t.ex = ex;
    t.rs1 = rs1; t.rs2 = rs2; t.e_r1 = r1; t.e_r2 = r2; t.e_ready = rdy;
    t.e_cv = cv; t.e_halt = halt; t.e_ret = ret; t.e_xcode = xc; t.e_xpc = xp;
    return t;
  endfunction

  task automatic drive(input logic v, input logic wen, input logic [4:0] rd,
                       input logic [63:0] wdata, input logic [63:0] pc, input logic ex,
                       input logic exp_ready);
    commit_t c;
    valid_i = v; wen_i = wen; rd_i = rd; wdata_i = wdata; pc_i = pc; exit_i = ex;
    if (v && exp_ready) begin
      c.pc    = pc;
      c.rd    = (wen && rd != 5'd0) ? rd : 5'd0;
      c.wdata = (wen && rd != 5'd0) ? wdata : 64'd0;
      exp_q.push_back(c);
    end
  endtask

  always @(negedge clock) begin
    if (reset === 1'b1 && commit_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL commit_unexpected: got commit_valid=1 at pc 0x%0h expected no commit", commit_pc_o);
      end else begin
        commit_t c;
        c = exp_q.pop_front();
        chk("commit_pc", commit_pc_o, c.pc);
        chk("commit_rd", 64'(commit_rd_o), 64'(c.rd));
        chk("commit_wdata", commit_wdata_o, c.wdata);
      end
    end
  end

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0);
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  localparam logic [63:0] PB = 64'h8000_0000;

  initial begin
    reset = 1'b0;
    rs1_i = 5'd0; rs2_i = 5'd0;
    drive(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0);

    //               v   wen rd    wdata       pc          ex  rs1   rs2   r1          r2          rdy cv  hlt ret xcode   xpc
    vecs[0]  = mk(1, 1, 5,  64'h1234, PB,         0, 5,  0,  0,          0,          1, 0, 0, 0, 0,  0);
    vecs[1]  = mk(0, 0, 0,  0,        0,          0, 5,  0,  64'h1234,   0,          1, 1, 0, 0, 0,  0);
    vecs[2]  = mk(1, 1, 3,  64'hA,    PB + 4,     0, 5,  3,  64'h1234,   0,          1, 0, 0, 1, 0,  0);
    vecs[3]  = mk(1, 1, 3,  64'hB,    PB + 8,     0, 3,  5,  64'hA,      64'h1234,   1, 1, 0, 1, 0,  0);
    vecs[4]  = mk(1, 1, 0,  64'hFFFF, PB + 12,    0, 3,  0,  64'hB,      0,          1, 1, 0, 2, 0,  0);
    vecs[5]  = mk(0, 0, 0,  0,        0,          0, 3,  0,  64'hB,      0,          1, 1, 0, 3, 0,  0);
    vecs[6]  = mk(1, 0, 7,  64'h5555, PB + 16,    0, 3,  0,  64'hB,      0,          1, 0, 0, 4, 0,  0);
    vecs[7]  = mk(0, 0, 0,  0,        0,          0, 7,  3,  0,          64'hB,      1, 1, 0, 4, 0,  0);
    vecs[8]  = mk(0, 0, 0,  0,        0,          0, 7,  0,  0,          0,          1, 0, 0, 5, 0,  0);
    vecs[9]  = mk(1, 1, 10, 64'd42,   PB + 20,    0, 10, 0,  0,          0,          1, 0, 0, 5, 0,  0);
    vecs[10] = mk(1, 0, 0,  0,        PB + 'h100, 1, 10, 0,  64'd42,     0,          1, 1, 0, 5, 0,  0);
    vecs[11] = mk(0, 0, 0,  0,        0,          0, 10, 0,  64'd42,     0,          0, 1, 0, 6, 0,  0);
    vecs[12] = mk(1, 1, 1,  64'd99,   PB + 24,    0, 10, 1,  64'd42,     0,          0, 0, 1, 7, 42, PB + 'h100);
    vecs[13] = mk(1, 1, 1,  64'd99,   PB + 24,    0, 10, 1,  64'd42,     0,          0, 0, 1, 7, 42, PB + 'h100);

    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    rs1_i = 5'd5;
    @(negedge clock);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_halted", 64'(halted_o), 64'd0);
    chk("rst_commit_valid", 64'(commit_valid_o), 64'd0);
    chk("rst_retired", retired_o, 64'd0);
    chk("rst_exit_code", exit_code_o, 64'd0);
    chk("rst_exit_pc", exit_pc_o, 64'd0);
    chk("rst_rdata1", rdata1_o, 64'd0);

    for (int i = 0; i < 14; i++) begin
      @(posedge clock); #1;
      rs1_i = vecs[i].rs1;
      rs2_i = vecs[i].rs2;
      drive(vecs[i].v, vecs[i].wen, vecs[i].rd, vecs[i].wdata, vecs[i].pc, vecs[i].ex,
            vecs[i].e_ready);
      @(negedge clock);
      chk($sformatf("v%0d_rdata1", i), rdata1_o, vecs[i].e_r1);
      chk($sformatf("v%0d_rdata2", i), rdata2_o, vecs[i].e_r2);
      chk($sformatf("v%0d_ready", i), 64'(ready_o), 64'(vecs[i].e_ready));
      chk($sformatf("v%0d_commit_valid", i), 64'(commit_valid_o), 64'(vecs[i].e_cv));
      chk($sformatf("v%0d_halted", i), 64'(halted_o), 64'(vecs[i].e_halt));
      chk($sformatf("v%0d_retired", i), retired_o, vecs[i].e_ret);
      chk($sformatf("v%0d_exit_code", i), exit_code_o, vecs[i].e_xcode);
      chk($sformatf("v%0d_exit_pc", i), exit_pc_o, vecs[i].e_xpc);
      chk($sformatf("v%0d_small_retired", i), 64'(s_ret), 64'(vecs[i].e_ret[1:0]));
      chk($sformatf("v%0d_small_halted", i), 64'(s_halted), 64'(vecs[i].e_halt));
    end

    // Exit bundle that itself writes x10.
    do_reset();
    rs1_i = 5'd10; rs2_i = 5'd3;
    @(negedge clock);
    chk("x_rst_x10", rdata1_o, 64'd0);
    chk("x_rst_x3", rdata2_o, 64'd0);
    chk("x_rst_halted", 64'(halted_o), 64'd0);
    chk("x_rst_exit_code", exit_code_o, 64'd0);
    @(posedge clock); #1;
    drive(1'b1, 1'b1, 5'd10, 64'd7, 64'h200, 1'b1, 1'b1);
    @(negedge clock);
    chk("x_accept_ready", 64'(ready_o), 64'd1);
    @(posedge clock); #1;
    drive(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0);
    @(negedge clock);
    chk("x_drain_ready", 64'(ready_o), 64'd0);
    chk("x_drain_bypass", rdata1_o, 64'd7);
    chk("x_drain_exit_code", exit_code_o, 64'd0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("x_halted", 64'(halted_o), 64'd1);
    chk("x_exit_code", exit_code_o, 64'd7);
    chk("x_exit_pc", exit_pc_o, 64'h200);
    chk("x_retired", retired_o, 64'd1);
    chk("x_x10", rdata1_o, 64'd7);

    // Reset lands between accept and commit: staged bundle must vanish.
    do_reset();
    @(posedge clock); #1;
    drive(1'b1, 1'b1, 5'd4, 64'h77, 64'h300, 1'b0, 1'b1);
    @(posedge clock); #1;
    drive(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    exp_q.delete();
    #1 reset = 1'b1;
    rs1_i = 5'd4;
    @(negedge clock);
    chk("r_commit_valid", 64'(commit_valid_o), 64'd0);
    chk("r_ready", 64'(ready_o), 64'd1);
    @(posedge clock); #1;
    @(negedge clock);
    chk("r_x4", rdata1_o, 64'd0);
    chk("r_retired", retired_o, 64'd0);
    chk("r_halted", 64'(halted_o), 64'd0);
    chk("r_small_retired", 64'(s_ret), 64'd0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
